// File: rtl/ram64_pkg.sv
// Shared widths, FSM state encoding and mode codes for the ram64 copy engine.
package ram64_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DEPTH  = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } copy_state_t;

  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

endpackage

// File: rtl/ram64.sv
// 64-word single-port memory: combinational read, write on rising clk when load is high.
module ram64 #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic [DATA_W-1:0] value,
  input  logic              load,
  input  logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] out
);

  logic [DATA_W-1:0] mem_q [1 << ADDR_W];

  always_ff @(posedge clk) begin
    if (load) mem_q[address] <= value;
  end

  assign out = mem_q[address];

endmodule

// File: rtl/ram64_copy_engine.sv
// Block copy / fill sequencer driving a ram64; memory-side outputs are registered
// from the next-state decode so they hold steady for the whole cycle before each write.
module ram64_copy_engine #(
  parameter int unsigned DATA_W = ram64_pkg::DATA_W,
  parameter int unsigned ADDR_W = ram64_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] dst,
  input  logic [ADDR_W:0]   len,
  input  logic [DATA_W-1:0] fill_value,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] ram_value,
  output logic              ram_load,
  output logic [ADDR_W-1:0] ram_address,
  input  logic [DATA_W-1:0] ram_out
);

  import ram64_pkg::*;

  localparam int unsigned LEN_W = ADDR_W + 1;
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(1 << ADDR_W);

  copy_state_t       state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d;
  logic [LEN_W-1:0]  rem_q, rem_d, len_clamped;
  logic              mode_q, mode_d;
  logic [DATA_W-1:0] fill_q, fill_d, data_q, data_d;
  logic              busy_q, busy_d, done_q, done_d, load_q, load_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] value_q, value_d;

  assign len_clamped = (len > LEN_MAX) ? LEN_MAX : len;

  // Next-state and next-output decode; outputs follow the state being entered.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rem_d   = rem_q;
    mode_d  = mode_q;
    fill_d  = fill_q;
    data_d  = data_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    load_d  = 1'b0;
    addr_d  = '0;
    value_d = '0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          src_d  = src;
          dst_d  = dst;
          rem_d  = len_clamped;
          mode_d = mode;
          fill_d = fill_value;
          if (len_clamped == '0)       state_d = DONE;
          else if (mode == MODE_COPY)  state_d = READ;
          else                         state_d = WRITE;
        end
      end
      READ: begin
        data_d  = ram_out;
        src_d   = src_q + ADDR_W'(1);
        state_d = WRITE;
      end
      WRITE: begin
        dst_d = dst_q + ADDR_W'(1);
        rem_d = rem_q - LEN_W'(1);
        if (rem_q == LEN_W'(1))        state_d = DONE;
        else if (mode_q == MODE_COPY)  state_d = READ;
        else                           state_d = WRITE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
    load_d = (state_d == WRITE);
    if (state_d == READ) addr_d = src_d;
    if (state_d == WRITE) begin
      addr_d  = dst_d;
      value_d = (mode_d == MODE_FILL) ? fill_d : data_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      mode_q  <= 1'b0;
      fill_q  <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      load_q  <= 1'b0;
      addr_q  <= '0;
      value_q <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      mode_q  <= mode_d;
      fill_q  <= fill_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      load_q  <= load_d;
      addr_q  <= addr_d;
      value_q <= value_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign ram_load    = load_q;
  assign ram_address = addr_q;
  assign ram_value   = value_q;

endmodule

// File: tb/tb_ram64_copy_engine.sv
// Directed bench for ram64_copy_engine driving a real ram64; the bench can take over
// the memory port between commands to preload and inspect words.
module tb_ram64_copy_engine;

  logic        clk;
  logic        reset;
  logic        start;
  logic        mode;
  logic [5:0]  src, dst;
  logic [6:0]  len;
  logic [15:0] fill_value;
  logic        busy, done;
  logic [15:0] ram_value;
  logic        ram_load;
  logic [5:0]  ram_address;
  logic [15:0] ram_out;

  logic        tb_sel, tb_load;
  logic [5:0]  tb_addr;
  logic [15:0] tb_val;
  logic        m_load;
  logic [5:0]  m_addr;
  logic [15:0] m_val;

  int n_vec = 0;
  int n_err = 0;

  ram64_copy_engine dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .src(src), .dst(dst),
    .len(len), .fill_value(fill_value), .busy(busy), .done(done),
    .ram_value(ram_value), .ram_load(ram_load), .ram_address(ram_address),
    .ram_out(ram_out)
  );

  assign m_load = tb_sel ? tb_load : ram_load;
  assign m_addr = tb_sel ? tb_addr : ram_address;
  assign m_val  = tb_sel ? tb_val  : ram_value;

  ram64 u_ram (.clk(clk), .value(m_val), .load(m_load), .address(m_addr), .out(ram_out));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        mode;
    logic [5:0]  src;
    logic [5:0]  dst;
    logic [6:0]  len;
    logic [15:0] fill;
    int          exp_done;
    int          exp_loads;
  } vec_t;

  typedef struct packed {
    int          vi;
    logic [5:0]  a;
    logic [15:0] v;
  } word_t;

  localparam int NV = 6;
  vec_t  vecs [NV];
  word_t pres[$];
  word_t chks[$];

  function automatic logic [15:0] pat(input int a);
    return 16'hC000 | 16'(a);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tb_write(input logic [5:0] a, input logic [15:0] v);
    @(negedge clk);
    tb_sel = 1'b1; tb_addr = a; tb_val = v; tb_load = 1'b1;
    @(posedge clk);
    #1 tb_load = 1'b0;
  endtask

  task automatic tb_read(input logic [5:0] a, output logic [15:0] v);
    @(negedge clk);
    tb_sel = 1'b1; tb_load = 1'b0; tb_addr = a;
    #1 v = ram_out;
  endtask

  task automatic init_mem();
    for (int i = 0; i < 64; i++) tb_write(6'(i), pat(i));
  endtask

  task automatic mem_check(input string name, input logic [5:0] a, input logic [15:0] exp);
    logic [15:0] v;
    tb_read(a, v);
    check($sformatf("%s mem[%0d]", name, a), 32'(v), 32'(exp));
  endtask

  task automatic issue(input logic m, input logic [5:0] s, input logic [5:0] d,
                       input logic [6:0] l, input logic [15:0] f);
    @(negedge clk);
    tb_sel = 1'b0; tb_load = 1'b0;
    mode = m; src = s; dst = d; len = l; fill_value = f; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Cycle k is the k-th cycle after the accepting edge, sampled at its falling edge.
  task automatic run_cmd(input logic m, input logic [5:0] s, input logic [5:0] d,
                         input logic [6:0] l, input logic [15:0] f,
                         output int done_cyc, output int loads, output logic busy1);
    issue(m, s, d, l, f);
    done_cyc = -1; loads = 0; busy1 = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (c == 1) busy1 = busy;
      if (ram_load) loads++;
      if (done) begin
        done_cyc = c;
        break;
      end
    end
  endtask

  initial begin
    int          dc, lc;
    logic        b1;
    logic [15:0] rv;

    reset = 1'b1; start = 1'b0; mode = 1'b0; src = '0; dst = '0; len = '0;
    fill_value = '0; tb_sel = 1'b1; tb_load = 1'b0; tb_addr = '0; tb_val = '0;

    vecs[0] = '{1'b1, 6'd0,  6'd5,  7'd3,   16'h00AA, 4,  3};
    vecs[1] = '{1'b0, 6'd3,  6'd45, 7'd2,   16'h0000, 5,  2};
    vecs[2] = '{1'b1, 6'd0,  6'd62, 7'd4,   16'h1234, 5,  4};
    vecs[3] = '{1'b0, 6'd10, 6'd11, 7'd3,   16'h0000, 7,  3};
    vecs[4] = '{1'b1, 6'd0,  6'd20, 7'd100, 16'hBEEF, 65, 64};
    vecs[5] = '{1'b0, 6'd7,  6'd30, 7'd0,   16'h0000, 1,  0};

    pres.push_back('{1, 6'd3,  16'd3});
    pres.push_back('{1, 6'd4,  16'd15});
    pres.push_back('{3, 6'd10, 16'd7});
    pres.push_back('{3, 6'd11, 16'd9});

    chks.push_back('{0, 6'd5,  16'h00AA});
    chks.push_back('{0, 6'd6,  16'h00AA});
    chks.push_back('{0, 6'd7,  16'h00AA});
    chks.push_back('{0, 6'd4,  pat(4)});
    chks.push_back('{0, 6'd8,  pat(8)});
    chks.push_back('{1, 6'd45, 16'd3});
    chks.push_back('{1, 6'd46, 16'd15});
    chks.push_back('{1, 6'd44, pat(44)});
    chks.push_back('{1, 6'd47, pat(47)});
    chks.push_back('{2, 6'd62, 16'h1234});
    chks.push_back('{2, 6'd63, 16'h1234});
    chks.push_back('{2, 6'd0,  16'h1234});
    chks.push_back('{2, 6'd1,  16'h1234});
    chks.push_back('{2, 6'd2,  pat(2)});
    chks.push_back('{2, 6'd61, pat(61)});
    chks.push_back('{3, 6'd10, 16'd7});
    chks.push_back('{3, 6'd11, 16'd7});
    chks.push_back('{3, 6'd12, 16'd7});
    chks.push_back('{3, 6'd13, 16'd7});
    chks.push_back('{3, 6'd14, pat(14)});
    chks.push_back('{4, 6'd20, 16'hBEEF});
    chks.push_back('{4, 6'd19, 16'hBEEF});
    chks.push_back('{4, 6'd0,  16'hBEEF});
    chks.push_back('{4, 6'd63, 16'hBEEF});
    chks.push_back('{4, 6'd42, 16'hBEEF});
    chks.push_back('{5, 6'd30, pat(30)});
    chks.push_back('{5, 6'd7,  pat(7)});

    // Reset state.
    #12;
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst ram_load", 32'(ram_load), 32'd0);
    check("rst ram_address", 32'(ram_address), 32'd0);
    check("rst ram_value", 32'(ram_value), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int vi = 0; vi < NV; vi++) begin
      init_mem();
      foreach (pres[i]) if (pres[i].vi == vi) tb_write(pres[i].a, pres[i].v);
      run_cmd(vecs[vi].mode, vecs[vi].src, vecs[vi].dst, vecs[vi].len, vecs[vi].fill,
              dc, lc, b1);
      check($sformatf("v%0d done cycle", vi), 32'(dc), 32'(vecs[vi].exp_done));
      check($sformatf("v%0d load cycles", vi), 32'(lc), 32'(vecs[vi].exp_loads));
      check($sformatf("v%0d busy c1", vi), 32'(b1), 32'd1);
      foreach (chks[i])
        if (chks[i].vi == vi) mem_check($sformatf("v%0d", vi), chks[i].a, chks[i].v);
    end

    // A second start while busy is ignored.
    init_mem();
    issue(1'b1, 6'd0, 6'd40, 7'd2, 16'h5555);
    @(negedge clk);
    check("ign busy c1", 32'(busy), 32'd1);
    mode = 1'b1; dst = 6'd50; len = 7'd1; fill_value = 16'h6666; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("ign done c2", 32'(done), 32'd0);
    @(negedge clk);
    check("ign done c3", 32'(done), 32'd1);
    @(negedge clk);
    check("ign busy c4", 32'(busy), 32'd0);
    check("ign load c4", 32'(ram_load), 32'd0);
    mem_check("ign", 6'd40, 16'h5555);
    mem_check("ign", 6'd41, 16'h5555);
    mem_check("ign", 6'd50, pat(50));

    // Reset during the third WRITE of a 5-word copy.
    init_mem();
    issue(1'b0, 6'd0, 6'd32, 7'd5, 16'h0000);
    for (int c = 1; c <= 6; c++) @(negedge clk);
    check("rmid load before", 32'(ram_load), 32'd1);
    reset = 1'b1;
    #1;
    check("rmid load", 32'(ram_load), 32'd0);
    check("rmid busy", 32'(busy), 32'd0);
    check("rmid address", 32'(ram_address), 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    mem_check("rmid", 6'd32, pat(0));
    mem_check("rmid", 6'd33, pat(1));
    mem_check("rmid", 6'd34, pat(34));
    mem_check("rmid", 6'd35, pat(35));
    mem_check("rmid", 6'd36, pat(36));
    run_cmd(1'b1, 6'd0, 6'd36, 7'd1, 16'h7777, dc, lc, b1);
    check("post-reset done cycle", 32'(dc), 32'd2);
    check("post-reset loads", 32'(lc), 32'd1);
    mem_check("post-reset", 6'd36, 16'h7777);
    mem_check("post-reset", 6'd37, pat(37));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
